hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall controller downstream of the forwarding unit. Combines no_hazard (load-use), dmem

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/hazard_perf_ctr.sv | 44 ++++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared fetch-FSM state encoding and pipeline constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    F_WAIT   = 2'd0,
    F_SQUASH = 2'd1,
    F_HOLD   = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 -- the datapath inserts this into IF/ID on bubble_ifid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/hazard_perf_ctr.sv
// ============================================================================
// Module      : hazard_perf_ctr
// Description : Three enable-driven wrapping event counters for stall stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_perf_ctr #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_dmem,
  input  logic            en_loaduse,
  input  logic            en_flush,
  output logic [XLEN-1:0] cnt_dmem,
  output logic [XLEN-1:0] cnt_loaduse,
  output logic [XLEN-1:0] cnt_flush
);

  localparam logic [XLEN-1:0] C_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic [2:0]      en;
  logic [XLEN-1:0] cnt [3];

  assign en = {en_flush, en_loaduse, en_dmem};

  for (genvar i = 0; i < 3; i++) begin : g_ctr
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (en[i]) begin
        cnt[i] <= cnt[i] + C_ONE;
      end
    end
  end

  assign cnt_dmem    = cnt[0];
  assign cnt_loaduse = cnt[1];
  assign cnt_flush   = cnt[2];

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline stall/flush controller with fetch FSM and skid buffer.
//               Optional event counters built when HAZARD_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            no_hazard,
  input  logic            br_redirect,
  input  logic            dmem_req,
  input  logic            dmem_resp,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_read,
  output logic            load_pc,
  output logic            load_ifid,
  output logic            load_idex,
  output logic            load_exmem,
  output logic            load_memwb,
  output logic            bubble_ifid,
  output logic            bubble_idex,
  output logic            bubble_exmem,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] cnt_dmem,
  output logic [XLEN-1:0] cnt_loaduse,
  output logic [XLEN-1:0] cnt_flush
);

  fetch_state_t    state;
  logic [XLEN-1:0] skid;

  logic freeze;
  logic lu;
  logic adv;
  logic redir;
  logic fetch_ok;

  assign freeze   = dmem_req & ~dmem_resp;
  assign lu       = ~no_hazard;
  assign adv      = ~freeze & ~lu;
  assign redir    = br_redirect & adv;
  assign fetch_ok = ((state == F_WAIT) & imem_resp) | (state == F_HOLD);

  assign ifid_instr = (state == F_HOLD) ? skid : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_WAIT;
      skid  <= '0;
    end else begin
      case (state)
        F_WAIT: begin
          if (imem_resp && !adv) begin
            state <= F_HOLD;
            skid  <= imem_rdata;
          end else if (!imem_resp && redir) begin
            state <= F_SQUASH;
          end
        end
        F_SQUASH: begin
          // wrong-path response is dropped here and never reaches IF/ID
          if (imem_resp) begin
            state <= F_WAIT;
          end
        end
        F_HOLD: begin
          if (adv) begin
            state <= F_WAIT;
          end
        end
        default: state <= F_WAIT;
      endcase
    end
  end

  always_comb begin
    imem_read    = 1'b0;
    load_pc      = 1'b0;
    load_ifid    = 1'b0;
    load_idex    = 1'b0;
    load_exmem   = 1'b0;
    load_memwb   = 1'b0;
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    if (!rst) begin
      imem_read = (state != F_HOLD);
      // a dmem freeze holds every stage; a pending redirect waits it out
      if (!freeze) begin
        load_memwb   = 1'b1;
        load_exmem   = 1'b1;
        bubble_exmem = lu;
        load_idex    = ~lu;
        bubble_idex  = redir;
        load_ifid    = ~lu;
        bubble_ifid  = redir | ~fetch_ok;
        load_pc      = redir | (adv & fetch_ok);
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  hazard_perf_ctr #(
    .XLEN (XLEN)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .en_dmem     (freeze),
    .en_loaduse  (~freeze & lu),
    .en_flush    (redir),
    .cnt_dmem    (cnt_dmem),
    .cnt_loaduse (cnt_loaduse),
    .cnt_flush   (cnt_flush)
  );
`else
  assign cnt_dmem    = '0;
  assign cnt_loaduse = '0;
  assign cnt_flush   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl; counter expectations follow
//               HAZARD_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int XLEN = 32;

  // ctrl vector: {imem_read, load_pc, ifid, idex, exmem, memwb, b_ifid, b_idex, b_exmem}
  localparam logic [8:0] C_RST     = 9'b0_0_0000_000;
  localparam logic [8:0] C_IDLE    = 9'b1_0_1111_100;
  localparam logic [8:0] C_FETCH   = 9'b1_1_1111_000;
  localparam logic [8:0] C_LU      = 9'b1_0_0011_101;
  localparam logic [8:0] C_LU_RESP = 9'b1_0_0011_001;
  localparam logic [8:0] C_FRZ_W   = 9'b1_0_0000_000;
  localparam logic [8:0] C_FRZ_H   = 9'b0_0_0000_000;
  localparam logic [8:0] C_REL_H   = 9'b0_1_1111_000;
  localparam logic [8:0] C_REDIR   = 9'b1_1_1111_110;
  localparam logic [8:0] C_REDIR_H = 9'b0_1_1111_110;

  logic            clk = 1'b0;
  logic            rst;
  logic            no_hazard, br_redirect, dmem_req, dmem_resp, imem_resp;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_read, load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic            bubble_ifid, bubble_idex, bubble_exmem;
  logic [XLEN-1:0] ifid_instr, cnt_dmem, cnt_loaduse, cnt_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .no_hazard    (no_hazard),
    .br_redirect  (br_redirect),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .imem_read    (imem_read),
    .load_pc      (load_pc),
    .load_ifid    (load_ifid),
    .load_idex    (load_idex),
    .load_exmem   (load_exmem),
    .load_memwb   (load_memwb),
    .bubble_ifid  (bubble_ifid),
    .bubble_idex  (bubble_idex),
    .bubble_exmem (bubble_exmem),
    .ifid_instr   (ifid_instr),
    .cnt_dmem     (cnt_dmem),
    .cnt_loaduse  (cnt_loaduse),
    .cnt_flush    (cnt_flush)
  );

  typedef struct {
    logic [8:0]  ctrl;
    logic        care;
    logic [31:0] instr;
    logic [31:0] cd;
    logic [31:0] clu;
    logic [31:0] cfl;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_cd = 0, m_clu = 0, m_cfl = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // one cycle of stimulus; expected outputs for that cycle go onto the scoreboard
  task automatic step(input logic r, input logic dreq, input logic dresp, input logic nh,
                      input logic br, input logic iresp, input logic [31:0] rd,
                      input logic [8:0] ctrl, input logic care, input logic [31:0] instr);
    exp_t e;
    logic frz, lu, adv;
    @(posedge clk);
    #1;
    rst = r; dmem_req = dreq; dmem_resp = dresp; no_hazard = nh;
    br_redirect = br; imem_resp = iresp; imem_rdata = rd;
    e.ctrl = ctrl; e.care = care; e.instr = instr;
`ifdef HAZARD_CTRL_PERF_EN
    e.cd = m_cd; e.clu = m_clu; e.cfl = m_cfl;
`else
    e.cd = 0; e.clu = 0; e.cfl = 0;
`endif
    sb.push_back(e);
    frz = dreq & ~dresp;
    lu  = ~nh;
    adv = ~frz & ~lu;
    if (r) begin
      m_cd = 0; m_clu = 0; m_cfl = 0;
    end else begin
      if (frz) m_cd++;
      if (!frz && lu) m_clu++;
      if (br && adv) m_cfl++;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val("ctrl", {55'd0, imem_read, load_pc, load_ifid, load_idex, load_exmem,
                         load_memwb, bubble_ifid, bubble_idex, bubble_exmem}, {55'd0, e.ctrl});
      if (e.care) check_val("ifid_instr", {32'd0, ifid_instr}, {32'd0, e.instr});
      check_val("cnt_dmem", {32'd0, cnt_dmem}, {32'd0, e.cd});
      check_val("cnt_loaduse", {32'd0, cnt_loaduse}, {32'd0, e.clu});
      check_val("cnt_flush", {32'd0, cnt_flush}, {32'd0, e.cfl});
    end
  end

  initial begin
    rst = 1'b1; no_hazard = 1'b1; br_redirect = 1'b0; dmem_req = 1'b0;
    dmem_resp = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    @(posedge clk);
    // reset held two cycles
    step(1, 0, 0, 1, 0, 0, 32'h0, C_RST, 0, 32'h0);
    step(1, 0, 0, 1, 0, 1, 32'h1, C_RST, 0, 32'h0);
    // first fetch and straight-line code, response every 2nd cycle
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 0, 32'h0, C_IDLE, 0, 32'h0);
      step(0, 0, 0, 1, 0, 1, 32'h0050_0093, C_FETCH, 1, 32'h0050_0093);
    end
    // load-use bubble, then load-use coinciding with a fetch response (goes to skid)
    step(0, 0, 0, 0, 0, 0, 32'h0, C_LU, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'h0, C_IDLE, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0010_0073, C_LU_RESP, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'h1234_5678, C_REL_H, 1, 32'h0010_0073);
    // dmem freeze with imem response in its first cycle
    step(0, 1, 0, 1, 0, 1, 32'h00A0_0113, C_FRZ_W, 0, 32'h0);
    step(0, 1, 0, 1, 0, 0, 32'hFFFF_FFFF, C_FRZ_H, 1, 32'h00A0_0113);
    step(0, 1, 1, 1, 0, 0, 32'hFFFF_FFFF, C_REL_H, 1, 32'h00A0_0113);
    // redirect while fetch outstanding: wrong-path response squashed
    step(0, 0, 0, 1, 1, 0, 32'h0, C_REDIR, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'h0, C_IDLE, 0, 32'h0);
    step(0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF, C_IDLE, 0, 32'h0);
    step(0, 0, 0, 1, 0, 1, 32'h0050_0093, C_FETCH, 1, 32'h0050_0093);
    // redirect on a response cycle: fetched instr discarded, stays in wait
    step(0, 0, 0, 1, 1, 1, 32'h0000_0bad, C_REDIR, 0, 32'h0);
    step(0, 0, 0, 1, 0, 1, 32'h0020_0193, C_FETCH, 1, 32'h0020_0193);
    // redirect held by a freeze, acted on when dmem completes
    step(0, 1, 0, 1, 1, 0, 32'h0, C_FRZ_W, 0, 32'h0);
    step(0, 1, 1, 1, 1, 0, 32'h0, C_REDIR, 0, 32'h0);
    step(0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF, C_IDLE, 0, 32'h0);
    // load-use wins over a simultaneous redirect
    step(0, 0, 0, 0, 1, 0, 32'h0, C_LU, 0, 32'h0);
    // redirect out of the skid state
    step(0, 1, 0, 1, 0, 1, 32'h0030_0213, C_FRZ_W, 0, 32'h0);
    step(0, 0, 0, 1, 1, 0, 32'h0, C_REDIR_H, 1, 32'h0030_0213);
    step(0, 0, 0, 1, 0, 1, 32'h0040_0293, C_FETCH, 1, 32'h0040_0293);
    // reset mid-run clears counters and state
    step(1, 1, 0, 0, 1, 1, 32'h0, C_RST, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'h0, C_IDLE, 0, 32'h0);
    step(0, 0, 0, 1, 0, 1, 32'h0050_0093, C_FETCH, 1, 32'h0050_0093);
    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 5) begin
        @(posedge clk);
        guard++;
      end
      @(posedge clk);
      if (sb.size() > 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded, expected completion", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
